// File: rtl/seven_segment_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_driver_if : control / display bus of the digit scanner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seven_segment_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   digits_in;
  logic [DIGITS-1:0]     blank_mask;
  logic                  lz_en;
  logic [3:0]            nibble_out;
  logic [DIGITS-1:0]     digit_sel;
  logic                  blank;
  logic                  frame_done;

  modport master (
    output enable, load, digits_in, blank_mask, lz_en,
    input  nibble_out, digit_sel, blank, frame_done
  );

  modport slave (
    input  enable, load, digits_in, blank_mask, lz_en,
    output nibble_out, digit_sel, blank, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/seven_segment_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_driver : multiplexed seven-segment digit scanner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seven_segment_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  seven_segment_scan_driver_if.slave    bus
);

  localparam int                CNT_W      = $clog2(SCAN_DIV);
  localparam int                IDX_W      = $clog2(DIGITS);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] C_SEL_OFF  = {DIGITS{SEL_ACTIVE_LOW}};

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_en;
  logic [4*DIGITS-1:0] r_disp;
  logic [4*DIGITS-1:0] r_pend;
  logic                r_pend_v;
  logic                r_frame_done;

  logic                w_cnt_last;
  logic                w_boundary;
  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_hi_zero;
  logic [DIGITS-1:0]   w_suppress;
  logic [DIGITS-1:0]   w_onehot;
  logic                w_dark;

  assign w_cnt_last = (r_cnt == C_CNT_LAST);
  assign w_boundary = bus.enable & w_cnt_last & (r_idx == C_IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_en         <= 1'b0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_en <= bus.enable;

      if (!bus.enable) begin
        r_cnt        <= '0;
        r_idx        <= '0;
        r_frame_done <= 1'b0;
      end else begin
        r_frame_done <= w_boundary;
        if (w_cnt_last) begin
          r_cnt <= '0;
          r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      // The display value only moves at a frame wrap, so a frame is never torn.
      if (w_boundary) begin
        if (bus.load) begin
          r_disp <= bus.digits_in;
        end else if (r_pend_v) begin
          r_disp <= r_pend;
        end
        r_pend_v <= 1'b0;
      end else if (bus.load) begin
        r_pend   <= bus.digits_in;
        r_pend_v <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_nib
    assign w_nib[k] = r_disp[4*k +: 4];
  end

  // w_hi_zero[k]: every nibble from the top digit down to k is zero.
  always_comb begin
    w_hi_zero             = '0;
    w_hi_zero[DIGITS-1]   = (w_nib[DIGITS-1] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      w_hi_zero[k] = w_hi_zero[k+1] & (w_nib[k] == 4'h0);
    end
    w_suppress    = w_hi_zero & {DIGITS{bus.lz_en}};
    w_suppress[0] = 1'b0;
  end

  assign w_onehot = DIGITS'(1) << r_idx;
  assign w_dark   = ~r_en | bus.blank_mask[r_idx] | w_suppress[r_idx];

  always_comb begin
    bus.nibble_out = 4'h0;
    bus.digit_sel  = C_SEL_OFF;
    bus.blank      = 1'b1;
    if (!w_dark) begin
      bus.nibble_out = w_nib[r_idx];
      bus.digit_sel  = SEL_ACTIVE_LOW ? ~w_onehot : w_onehot;
      bus.blank      = 1'b0;
    end
  end

  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scan_driver : directed self-checking bench, 4 digits x 4
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seven_segment_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seven_segment_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seven_segment_scan_driver #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {frame_done, blank, digit_sel, nibble_out}
  function automatic logic [9:0] outs();
    return {bus.frame_done, bus.blank, bus.digit_sel, bus.nibble_out};
  endfunction

  task automatic wait_frame(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  task automatic verify_frame(input string tag, input logic [15:0] v, input logic [3:0] lit);
    for (int i = 0; i < DIGITS*SCAN_DIV; i++) begin
      int         d;
      logic [3:0] nib;
      logic [3:0] sel;
      logic       bl;
      d = i / SCAN_DIV;
      if (lit[d]) begin
        nib = v[4*d +: 4];
        sel = ~(4'b0001 << d);
        bl  = 1'b0;
      end else begin
        nib = 4'h0;
        sel = 4'hF;
        bl  = 1'b1;
      end
      check($sformatf("%s_c%0d", tag, i), outs(), {(i == 0), bl, sel, nib});
      tick();
    end
  endtask

  // Called in the cycle right after a frame wrap; the new value shows one frame later.
  task automatic commit(input string tag, input logic [15:0] v);
    bus.load      = 1'b1;
    bus.digits_in = v;
    tick();
    bus.load = 1'b0;
    wait_frame(tag, 15);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.enable     = 1'b0;
    bus.load       = 1'b0;
    bus.digits_in  = '0;
    bus.blank_mask = '0;
    bus.lz_en      = 1'b0;
    rst_n          = 1'b0;
    tick();
    tick();
    check("rst_outs", outs(), {1'b0, 1'b1, 4'hF, 4'h0});
    rst_n = 1'b1;
    tick();
    check("idle_dark", outs(), {1'b0, 1'b1, 4'hF, 4'h0});

    // Scan order, timing and frame_done period
    bus.enable    = 1'b1;
    bus.load      = 1'b1;
    bus.digits_in = 16'h1234;
    tick();
    bus.load = 1'b0;
    check("t1_first", outs(), {1'b0, 1'b0, 4'hE, 4'h0});
    wait_frame("t1_wait", 15);
    verify_frame("t1", 16'h1234, 4'hF);
    verify_frame("t1b", 16'h1234, 4'hF);

    // Two mid-frame loads: last one wins, nothing changes mid-frame
    tick();
    tick();
    bus.load      = 1'b1;
    bus.digits_in = 16'hAAAA;
    tick();
    bus.load = 1'b0;
    repeat (3) tick();
    bus.load      = 1'b1;
    bus.digits_in = 16'h5555;
    tick();
    bus.load = 1'b0;
    check("t2_hold", outs(), {1'b0, 1'b0, 4'hD, 4'h3});
    wait_frame("t2_wait", 9);
    verify_frame("t2", 16'h5555, 4'hF);

    // Load on the wrap edge beats a pending value and clears it
    tick();
    bus.load      = 1'b1;
    bus.digits_in = 16'h1111;
    tick();
    bus.load = 1'b0;
    repeat (13) tick();
    check("t3_pre", outs(), {1'b0, 1'b0, 4'h7, 4'h5});
    bus.load      = 1'b1;
    bus.digits_in = 16'hBEEF;
    tick();
    bus.load = 1'b0;
    verify_frame("t3", 16'hBEEF, 4'hF);
    verify_frame("t3b", 16'hBEEF, 4'hF);

    // Leading-zero suppression
    bus.lz_en = 1'b1;
    commit("t4a_wait", 16'h0700);
    verify_frame("t4a", 16'h0700, 4'b0111);
    commit("t4b_wait", 16'h0070);
    verify_frame("t4b", 16'h0070, 4'b0011);
    commit("t4c_wait", 16'h0000);
    verify_frame("t4c", 16'h0000, 4'b0001);
    bus.lz_en = 1'b0;
    verify_frame("t4d", 16'h0000, 4'hF);

    // Per-digit blanking
    commit("t5_wait", 16'hBEEF);
    bus.blank_mask = 4'b0010;
    verify_frame("t5", 16'hBEEF, 4'b1101);
    bus.blank_mask = 4'b0000;

    // Enable drop mid-digit 2 with a load while dark
    repeat (9) tick();
    bus.enable = 1'b0;
    tick();
    check("t6_off", outs(), {1'b0, 1'b1, 4'hF, 4'h0});
    for (int i = 0; i < 10; i++) begin
      bus.load      = (i == 3);
      bus.digits_in = 16'h9876;
      tick();
      check($sformatf("t6_dark%0d", i), outs(), {1'b0, 1'b1, 4'hF, 4'h0});
    end
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick();
    check("t6_restart", outs(), {1'b0, 1'b0, 4'hE, 4'hF});
    wait_frame("t6_wait", 15);
    verify_frame("t6", 16'h9876, 4'hF);

    // One-edge reset mid-scan
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid", outs(), {1'b0, 1'b1, 4'hF, 4'h0});
    rst_n = 1'b1;
    tick();
    check("rst_after", outs(), {1'b0, 1'b0, 4'hE, 4'h0});
    wait_frame("rst_wait", 15);
    verify_frame("rst_frame", 16'h0000, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
